// File: rtl/joy_emu_if.sv
// CPU-side bus and host-side button handshake for the virtual controller responder.
// The master drives the CPU bus and host controls; the slave (joy_emu) answers.
interface joy_emu_if;
   logic        cpu_m2;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_dati;
   logic        en;
   logic        btn_we;
   logic [7:0]  btn_p0;
   logic [7:0]  btn_p1;
   logic [7:0]  dout;
   logic        oe;
   logic        pend;
   logic [15:0] frame_ctr;

   modport master (
      output cpu_m2, cpu_addr, cpu_rw, cpu_dati, en, btn_we, btn_p0, btn_p1,
      input  dout, oe, pend, frame_ctr
   );

   modport slave (
      input  cpu_m2, cpu_addr, cpu_rw, cpu_dati, en, btn_we, btn_p0, btn_p1,
      output dout, oe, pend, frame_ctr
   );
endinterface

// File: rtl/joy_emu.sv
// Virtual controller responder: answers $4016/$4017 strobe/serial reads with
// host-supplied button bytes, swapped in only at strobe-fall frame boundaries.
module joy_emu #(
   parameter logic [15:0] ADDR_P0  = 16'h4016,
   parameter logic [15:0] ADDR_P1  = 16'h4017,
   parameter logic [7:0]  OPEN_BUS = 8'h40
) (
   input logic     clk,
   input logic     sys_rst_n,
   joy_emu_if.slave bus
);

   logic        m2_s1, m2_s2, m2_d;
   logic        m2_fall;
   logic [15:0] cap_addr;
   logic        cap_rw;
   logic        cap_d0;

   logic        strobe;
   logic [7:0]  shreg0, shreg1;
   logic [3:0]  cnt0, cnt1;
   logic [7:0]  act0, act1;
   logic [7:0]  pend0, pend1;
   logic        pend_q;
   logic [15:0] frame_q;

   logic        wr_p0, rd_p0, rd_p1, strobe_fall;
   logic [7:0]  act0_new, act1_new;
   logic        sel_p1, port_hit, ser_bit;

   // The extra delay stage turns the synchronised m2 into a one-clk falling-edge pulse.
   assign m2_fall     = m2_d & ~m2_s2;
   assign wr_p0       = m2_fall & ~cap_rw & (cap_addr == ADDR_P0);
   assign rd_p0       = m2_fall &  cap_rw & (cap_addr == ADDR_P0);
   assign rd_p1       = m2_fall &  cap_rw & (cap_addr == ADDR_P1);
   assign strobe_fall = wr_p0 & strobe & ~cap_d0;

   // A host write landing on the latching edge bypasses the pending registers.
   assign act0_new = bus.btn_we ? bus.btn_p0 : (pend_q ? pend0 : act0);
   assign act1_new = bus.btn_we ? bus.btn_p1 : (pend_q ? pend1 : act1);

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m2_s1    <= 1'b0;
         m2_s2    <= 1'b0;
         m2_d     <= 1'b0;
         cap_addr <= '0;
         cap_rw   <= 1'b0;
         cap_d0   <= 1'b0;
         strobe   <= 1'b0;
         shreg0   <= '0;
         shreg1   <= '0;
         cnt0     <= '0;
         cnt1     <= '0;
         act0     <= '0;
         act1     <= '0;
         pend0    <= '0;
         pend1    <= '0;
         pend_q   <= 1'b0;
         frame_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         m2_s1 <= bus.cpu_m2;
         m2_s2 <= m2_s1;
         m2_d  <= m2_s2;

         if (m2_s2) begin
            cap_addr <= bus.cpu_addr;
            cap_rw   <= bus.cpu_rw;
            cap_d0   <= bus.cpu_dati[0];
         end

         if (bus.btn_we) begin
            pend0 <= bus.btn_p0;
            pend1 <= bus.btn_p1;
         end

         if (strobe_fall) begin
            act0    <= act0_new;
            act1    <= act1_new;
            shreg0  <= act0_new;
            shreg1  <= act1_new;
            cnt0    <= '0;
            cnt1    <= '0;
            pend_q  <= 1'b0;
            frame_q <= frame_q + 16'd1;
         end else begin
            if (bus.btn_we)
               pend_q <= 1'b1;
            if (m2_fall && strobe) begin
               shreg0 <= act0;
               shreg1 <= act1;
               cnt0   <= '0;
               cnt1   <= '0;
            end else begin
               if (rd_p0) begin
                  shreg0 <= {shreg0[6:0], 1'b1};
                  cnt0   <= (cnt0 == 4'd8) ? 4'd8 : cnt0 + 4'd1;
               end
               if (rd_p1) begin
                  shreg1 <= {shreg1[6:0], 1'b1};
                  cnt1   <= (cnt1 == 4'd8) ? 4'd8 : cnt1 + 4'd1;
               end
            end
         end

         if (wr_p0)
            strobe <= cap_d0;
      end
   end

   // Read response follows the live bus so the data is valid within the m2-high window.
   assign sel_p1   = (bus.cpu_addr == ADDR_P1);
   assign port_hit = (bus.cpu_addr == ADDR_P0) | sel_p1;
   assign ser_bit  = sel_p1 ? (strobe ? act1[7] : shreg1[7])
                            : (strobe ? act0[7] : shreg0[7]);

   assign bus.dout      = {OPEN_BUS[7:1], ser_bit};
   assign bus.oe        = bus.en & bus.cpu_m2 & bus.cpu_rw & port_hit;
   assign bus.pend      = pend_q;
   assign bus.frame_ctr = frame_q;

endmodule

// File: tb/tb_joy_emu.sv
// Bench for joy_emu: directed protocol scenarios plus random bus/host traffic,
// compared every settled clk against a frame/read-index model of the controller.
module tb_joy_emu;

   localparam logic [15:0] P0       = 16'h4016;
   localparam logic [15:0] P1       = 16'h4017;
   localparam logic [7:0]  OPEN_BUS = 8'h40;

   logic clk = 1'b0;
   logic sys_rst_n;
   always #5 clk = ~clk;

   joy_emu_if bus ();
   joy_emu dut (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_on = 1'b0;

   // Model: bytes in force for the frame, byte snapshot taken at the frame boundary,
   // and how many reads each port has seen since then.
   logic        m_strobe;
   logic [7:0]  m_act[2];
   logic [7:0]  m_pendb[2];
   logic        m_pend;
   logic [7:0]  m_snap[2];
   int          m_idx[2];
   logic [15:0] m_frame;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic m_bit(input int p);
      if (m_strobe) return m_act[p][7];
      if (m_idx[p] >= 8) return 1'b1;
      return m_snap[p][7 - m_idx[p]];
   endfunction

   task automatic model_reset();
      m_strobe = 1'b0;
      m_pend   = 1'b0;
      m_frame  = '0;
      for (int p = 0; p < 2; p++) begin
         m_act[p] = '0; m_pendb[p] = '0; m_snap[p] = '0; m_idx[p] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("oe", {15'd0, bus.oe},
               {15'd0, bus.en & bus.cpu_m2 & bus.cpu_rw & (bus.cpu_addr == P0 || bus.cpu_addr == P1)});
         check("pend", {15'd0, bus.pend}, {15'd0, m_pend});
         check("frame_ctr", bus.frame_ctr, m_frame);
         if (bus.cpu_addr == P0 || bus.cpu_addr == P1)
            check("dout", {8'd0, bus.dout},
                  {8'd0, OPEN_BUS[7:1], m_bit(bus.cpu_addr == P1 ? 1 : 0)});
      end
   end

   task automatic bus_op(input logic [15:0] a, input logic rw, input logic [7:0] d,
                         input logic we_fall, input logic [7:0] b0, input logic [7:0] b1,
                         output logic [7:0] rd, output logic rd_oe);
      logic latched;
      @(negedge clk); #1;
      bus.cpu_addr = a; bus.cpu_rw = rw; bus.cpu_dati = d;
      repeat (2) @(negedge clk);
      #1 bus.cpu_m2 = 1'b1;
      repeat (4) @(negedge clk);
      rd = bus.dout; rd_oe = bus.oe;
      #1 bus.cpu_m2 = 1'b0; chk_on = 1'b0;
      repeat (2) @(negedge clk);
      if (we_fall) begin
         #1 bus.btn_we = 1'b1; bus.btn_p0 = b0; bus.btn_p1 = b1;
      end
      @(negedge clk);
      #1 bus.btn_we = 1'b0;
      latched = 1'b0;
      if (!rw && a == P0) begin
         if (m_strobe && !d[0]) begin
            latched = 1'b1;
            if (we_fall) begin
               m_act[0] = b0; m_act[1] = b1;
            end else if (m_pend) begin
               m_act[0] = m_pendb[0]; m_act[1] = m_pendb[1];
            end
            m_pend = 1'b0;
            m_frame = m_frame + 16'd1;
         end
         if (m_strobe) begin
            m_snap[0] = m_act[0]; m_snap[1] = m_act[1]; m_idx[0] = 0; m_idx[1] = 0;
         end
         m_strobe = d[0];
      end else if (m_strobe) begin
         m_snap[0] = m_act[0]; m_snap[1] = m_act[1]; m_idx[0] = 0; m_idx[1] = 0;
      end else if (rw && (a == P0 || a == P1)) begin
         m_idx[a == P1 ? 1 : 0] = (m_idx[a == P1 ? 1 : 0] >= 8) ? 8 : m_idx[a == P1 ? 1 : 0] + 1;
      end
      if (we_fall && !latched) begin
         m_pendb[0] = b0; m_pendb[1] = b1; m_pend = 1'b1;
      end
      chk_on = 1'b1;
      @(negedge clk);
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] v, output logic o);
      bus_op(a, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, v, o);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      logic [7:0] v; logic o;
      bus_op(a, 1'b0, d, 1'b0, 8'h00, 8'h00, v, o);
   endtask

   task automatic host_we(input logic [7:0] b0, input logic [7:0] b1);
      @(negedge clk); #1;
      chk_on = 1'b0;
      bus.btn_we = 1'b1; bus.btn_p0 = b0; bus.btn_p1 = b1;
      @(negedge clk); #1;
      bus.btn_we = 1'b0;
      m_pendb[0] = b0; m_pendb[1] = b1; m_pend = 1'b1;
      chk_on = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      chk_on = 1'b0;
      sys_rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 sys_rst_n = 1'b1;
      chk_on = 1'b1;
   endtask

   initial begin
      logic [7:0] v;
      logic o;
      logic [7:0] seq_a5;
      logic [7:0] b0, b1;
      int op;

      sys_rst_n = 1'b0;
      bus.cpu_m2 = 1'b0; bus.cpu_addr = P0; bus.cpu_rw = 1'b1; bus.cpu_dati = '0;
      bus.en = 1'b1; bus.btn_we = 1'b0; bus.btn_p0 = '0; bus.btn_p1 = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1 sys_rst_n = 1'b1;
      chk_on = 1'b1;

      // Reset state, literal.
      @(negedge clk);
      check("rst_frame", bus.frame_ctr, 16'h0000);
      check("rst_dout", {8'd0, bus.dout}, 16'h0040);
      check("rst_pend", {15'd0, bus.pend}, 16'h0000);

      // A5 through port 0; a $4017 write must not touch strobe.
      host_we(8'hA5, 8'h3C);
      @(negedge clk);
      check("pend_set", {15'd0, bus.pend}, 16'h0001);
      wr(P0, 8'h01);
      wr(P0, 8'h00);
      check("pend_clr", {15'd0, bus.pend}, 16'h0000);
      check("frame_1", bus.frame_ctr, 16'h0001);
      wr(P1, 8'h01);
      seq_a5 = 8'b10100101;
      for (int i = 0; i < 8; i++) begin
         rd(P0, v, o);
         check($sformatf("a5_dout[%0d]", i), {8'd0, v}, seq_a5[7 - i] ? 16'h0041 : 16'h0040);
         check($sformatf("a5_oe[%0d]", i), {15'd0, o}, 16'h0001);
      end
      for (int i = 0; i < 4; i++) begin
         rd(P0, v, o);
         check($sformatf("tail_one[%0d]", i), {15'd0, v[0]}, 16'h0001);
      end

      // Port 1 = 80; port 0 reads unaffected by port 1 traffic.
      host_we(8'hA5, 8'h80);
      wr(P0, 8'h01);
      wr(P0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         rd(P1, v, o);
         check($sformatf("p1_80[%0d]", i), {15'd0, v[0]}, (i == 0) ? 16'h0001 : 16'h0000);
      end
      rd(P0, v, o);
      check("p0_after_p1_a", {15'd0, v[0]}, 16'h0001);
      rd(P0, v, o);
      check("p0_after_p1_b", {15'd0, v[0]}, 16'h0000);

      // Strobe held: reads return A without shifting; new bytes apply at the fall.
      wr(P0, 8'h01);
      for (int i = 0; i < 3; i++) begin
         rd(P0, v, o);
         check($sformatf("strobe_hold[%0d]", i), {15'd0, v[0]}, 16'h0001);
      end
      host_we(8'h00, 8'h00);
      wr(P0, 8'h00);
      rd(P0, v, o);
      check("after_mid_we", {15'd0, v[0]}, 16'h0000);

      // Bypass: btn_we on the latching m2_fall.
      wr(P0, 8'h01);
      bus_op(P0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h11, v, o);
      check("bypass_pend", {15'd0, bus.pend}, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         rd(P0, v, o);
         check($sformatf("bypass_ff[%0d]", i), {15'd0, v[0]}, 16'h0001);
      end

      // Reset mid-frame, then en=0 read still shifts.
      host_we(8'hA5, 8'h00);
      wr(P0, 8'h01);
      wr(P0, 8'h00);
      for (int i = 0; i < 3; i++) rd(P0, v, o);
      do_reset();
      @(negedge clk);
      check("rst2_frame", bus.frame_ctr, 16'h0000);
      rd(P0, v, o);
      check("rst2_bit", {15'd0, v[0]}, 16'h0000);
      host_we(8'hA5, 8'h00);
      wr(P0, 8'h01);
      wr(P0, 8'h00);
      rd(P0, v, o);
      check("en_bit0", {15'd0, v[0]}, 16'h0001);
      @(negedge clk); #1 bus.en = 1'b0;
      rd(P0, v, o);
      check("en0_oe", {15'd0, o}, 16'h0000);
      @(negedge clk); #1 bus.en = 1'b1;
      rd(P0, v, o);
      check("en_bit2", {15'd0, v[0]}, 16'h0001);

      // Random traffic against the model.
      for (int it = 0; it < 500; it++) begin
         op = $urandom_range(0, 12);
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         case (op)
            0: host_we(b0, b1);
            1: begin
               wr(P0, 8'h01);
               bus_op(P0, 1'b0, 8'h00, ($urandom_range(0, 3) == 0), b0, b1, v, o);
            end
            2: bus_op(P0, 1'b0, 8'($urandom), ($urandom_range(0, 7) == 0), b0, b1, v, o);
            3: wr(P1, 8'($urandom));
            4: rd(16'h8000 + 16'($urandom_range(0, 3)), v, o);
            5: begin @(negedge clk); #1 bus.en = 1'($urandom); end
            6: if ($urandom_range(0, 9) == 0) do_reset();
            7, 8: rd(P1, v, o);
            default: bus_op(P0, 1'b1, 8'h00, ($urandom_range(0, 7) == 0), b0, b1, v, o);
         endcase
      end

      repeat (4) @(negedge clk);
      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/joy_emu.md
Name: joy_emu

Overview:
- Virtual controller responder on the CPU bus. It answers the standard strobe/serial-read protocol at $4016/$4017 with button bytes supplied by the host (PI side).
- It is the device end of the protocol that the joypad reader sniffs. It is used for input injection, replay and menu control.
- It sits beside the save-state logic in the base mapper and drives the CPU data bus only on controller-port reads while enabled.

Parameters:
- ADDR_P0, 16'h4016, port 0 read address; strobe write address.
- ADDR_P1, 16'h4017, port 1 read address.
- OPEN_BUS, 8'h40, value placed on data bits 7:1 during a port read (bit 0 replaced by the serial bit).

Ports:
- clk  in  1  system clock, at least 8x the m2 frequency.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- cpu_m2  in  1  CPU m2, asynchronous to clk.
- cpu_addr  in  16  CPU address.
- cpu_rw  in  1  1 = read.
- cpu_dati  in  8  CPU data bus (write data).
- en  in  1  1 = respond on the bus.
- btn_we  in  1  one-clk pulse: load pending button bytes.
- btn_p0  in  8  port 0 buttons; bit7 = A ... bit0 = Right; 1 = pressed.
- btn_p1  in  8  port 1 buttons, same order.
- dout  out  8  data for CPU reads.
- oe  out  1  drive dout onto the CPU bus.
- pend  out  1  pending bytes not yet latched.
- frame_ctr  out  16  count of strobe 1->0 transitions.

Behaviour:
- Reset values (sys_rst_n=0, asynchronous):
  - strobe=0, shreg0/1=8'h00, cnt0/1=0.
  - act0/1=0, pend0/1=0, pend=0, frame_ctr=0.
  - dout = OPEN_BUS with bit0=0.
  - oe = 0 combinationally while en=0.
- m2 synchronisation:
  - cpu_m2 passes through a 2-FF synchroniser plus one delay stage. m2_fall = delayed & !synced.
  - cpu_addr, cpu_rw and cpu_dati are captured on every clk while synced m2 = 1.
  - All bus actions use the captured values at m2_fall, 3 clk after the real edge.
- Read response (combinational from live bus signals):
  - oe = en & cpu_m2 & cpu_rw & (cpu_addr == ADDR_P0 | cpu_addr == ADDR_P1).
  - dout = {OPEN_BUS[7:1], bit}. bit is shreg0[7] for port 0 and shreg1[7] for port 1; while strobe=1 it is act0[7] or act1[7].
- Strobe:
  - On m2_fall with a captured write to ADDR_P0, strobe <= dati[0].
  - Writes to ADDR_P1 (APU frame counter) are ignored.
- Load:
  - While strobe=1, on every m2_fall: shreg <= act, cnt <= 0.
  - On a strobe 1->0 transition: shreg <= act (the final snapshot) and frame_ctr <= frame_ctr + 1, wrapping 16'hFFFF -> 0.
- Shift:
  - On m2_fall with a captured read of port N and strobe=0: shregN <= {shregN[6:0], 1'b1}, cntN <= min(cntN+1, 8).
  - After 8 reads the port returns 1 indefinitely. The first read after the strobe falls returns A (bit7).
  - Reads while strobe=1 do not shift.
- Host handshake:
  - btn_we copies btn_p0/btn_p1 into pend0/pend1 and sets pend=1.
  - At the next strobe 1->0 transition, act <= pend bytes and pend clears. Bytes change only at frame boundaries.
  - If btn_we arrives in the same clk as the latching m2_fall, the new bytes are used (bypass) and pend stays 0.
  - A second btn_we before latching overwrites the pending bytes; the last write wins.
- en=0: oe=0, but strobe, shift and handshake tracking continue, so re-enabling mid-frame stays consistent.
- DMC double-read corruption is not mitigated; each sampled read shifts once.
- Reset mid-frame: state returns to reset values and reads return bit0=0 until the next strobe cycle.

Test Plan:
- Reset, en=1, btn_we with p0=8'hA5 -> pend=1. Write $4016=1 then 0 -> pend=0, frame_ctr=1. Eight reads of $4016 -> bit0 sequence 1,0,1,0,0,1,0,1; dout=8'h41/8'h40.
- After the sequence, 4 more reads of $4016 -> bit0=1 each time. cnt0 stays 8 and oe pulses only during m2 high.
- p1=8'h80, strobe cycle. Read $4017 once -> bit0=1; next 7 reads -> 0. Port 0 shreg is unchanged by $4017 reads.
- Strobe held 1, 3 reads of $4016 with act0[7]=1 -> all return 1, no shift. btn_we p0=8'h00 mid-strobe, then strobe falls -> first read returns 0.
- btn_we pulsed in the same clk as the strobe-fall m2_fall with p0=8'hFF -> 8 reads all 1, pend=0. Separately, a write to $4017 leaves strobe unchanged.
- Assert sys_rst_n=0 after 3 reads; release -> frame_ctr=0, read returns bit0=0. en=0 during a read -> oe=0, yet the shift still advances (next enabled read returns the following bit).
